// File: rtl/isqrt_seq.sv
// rtl/isqrt_seq.sv - iterative radix-2 integer square root, one root bit per clock
// Optional round-to-nearest with saturation; result held until out_ready.
module isqrt_seq #(
  parameter int DIN_W = 32,
  parameter int ROUND = 0,
  localparam int N  = DIN_W / 2,
  localparam int CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [DIN_W-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] dout,
  output logic [N:0]   rem,
  output logic         busy,
  output logic [1:0]   cstate
);

  if ((DIN_W % 2) != 0 || DIN_W < 4) begin : g_bad_width
    $error("isqrt_seq: DIN_W must be even and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [DIN_W-1:0] rad;
  logic [N-1:0]     root;
  logic [N+1:0]     rem_p;
  logic [CW-1:0]    cnt;

  logic [N+1:0]     rem_sh;
  logic [N+1:0]     trial;
  logic             take;
  logic             round_up;
  logic [N-1:0]     root_inc;

  // Partial remainder stays below 2^N between steps, so N+2 bits hold the shifted value.
  always_comb begin
    rem_sh   = {rem_p[N-1:0], rad[DIN_W-1 -: 2]};
    trial    = {root, 2'b01};
    take     = (rem_sh >= trial);
    round_up = (ROUND != 0) && (rem_p > {2'b00, root});
    root_inc = (&root) ? root : root + N'(1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid)              state_nx = CALC;
      CALC: if (cnt == CW'(N - 1))     state_nx = FIN;
      FIN:                             state_nx = DONE;
      DONE: if (out_ready)             state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rad   <= '0;
      root  <= '0;
      rem_p <= '0;
      cnt   <= '0;
      dout  <= '0;
      rem   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          rad   <= din;
          root  <= '0;
          rem_p <= '0;
          cnt   <= '0;
        end
        CALC: begin
          rad <= {rad[DIN_W-3:0], 2'b00};
          cnt <= cnt + CW'(1);
          if (take) begin
            rem_p <= rem_sh - trial;
            root  <= {root[N-2:0], 1'b1};
          end else begin
            rem_p <= rem_sh;
            root  <= {root[N-2:0], 1'b0};
          end
        end
        FIN: begin
          rem  <= rem_p[N:0];
          dout <= round_up ? root_inc : root;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC) || (state == FIN);
  assign cstate    = state;

endmodule

// File: tb/tb_isqrt_seq.sv
// tb/tb_isqrt_seq.sv - directed bench for isqrt_seq (32-bit floor/round pair, 16-bit instance)
module tb_isqrt_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [31:0] din;
  logic        c_in_valid, c_out_ready;
  logic [15:0] c_din;

  logic        a_in_ready, a_out_valid, a_busy, b_in_ready, b_out_valid, b_busy;
  logic [15:0] a_dout, b_dout;
  logic [16:0] a_rem, b_rem;
  logic [1:0]  a_cstate, b_cstate, c_cstate;
  logic        c_in_ready, c_out_valid, c_busy;
  logic [7:0]  c_dout;
  logic [8:0]  c_rem;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  isqrt_seq #(.DIN_W(32), .ROUND(0)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready), .din(din),
    .out_valid(a_out_valid), .out_ready(out_ready), .dout(a_dout), .rem(a_rem),
    .busy(a_busy), .cstate(a_cstate));

  isqrt_seq #(.DIN_W(32), .ROUND(1)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready), .din(din),
    .out_valid(b_out_valid), .out_ready(out_ready), .dout(b_dout), .rem(b_rem),
    .busy(b_busy), .cstate(b_cstate));

  isqrt_seq #(.DIN_W(16), .ROUND(0)) u_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready), .din(c_din),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .dout(c_dout), .rem(c_rem),
    .busy(c_busy), .cstate(c_cstate));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives both 32-bit instances in lockstep; e0 = floor root, e1 = rounded root.
  task automatic run32(input logic [31:0] d, input logic [15:0] e0, input logic [15:0] e1,
                       input logic [16:0] er, input int hold);
    int lat;
    logic [15:0] h_dout;
    logic [16:0] h_rem;
    din = d;
    in_valid = 1'b1;
    check("accept_ready", a_in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    din = $urandom();
    lat = 0;
    while (!a_out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("lat32", lat, 17);
    check("b_valid", b_out_valid, 1'b1);
    check("a_dout", a_dout, e0);
    check("a_rem", a_rem, er);
    check("b_dout", b_dout, e1);
    check("b_rem", b_rem, er);
    check("done_in_ready", a_in_ready, 1'b0);
    check("done_busy", a_busy, 1'b0);
    h_dout = a_dout;
    h_rem  = a_rem;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      tick();
      check("hold_valid", a_out_valid, 1'b1);
      check("hold_dout", a_dout, h_dout);
      check("hold_rem", a_rem, h_rem);
      check("hold_in_ready", a_in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_valid", a_out_valid, 1'b0);
    check("drain_in_ready", a_in_ready, 1'b1);
  endtask

  task automatic run16(input logic [15:0] d);
    int lat;
    c_din = d;
    c_in_valid = 1'b1;
    tick();
    c_in_valid = 1'b0;
    lat = 0;
    while (!c_out_valid && lat < 30) begin
      tick();
      lat++;
    end
    check("lat16", lat, 9);
    check("c_identity", 32'(c_dout) * 32'(c_dout) + 32'(c_rem), 32'(d));
    check("c_rem_bound", (32'(c_rem) <= 2 * 32'(c_dout)), 1'b1);
    c_out_ready = 1'b1;
    tick();
    c_out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; din = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b0; c_din = '0;
    tick();
    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_dout", a_dout, 0);
    check("rst_rem", a_rem, 0);
    check("rst_cstate", a_cstate, 0);
    reset = 1'b0;
    tick();

    run32(32'd0,          16'd0,     16'd0,     17'd0,      0);
    run32(32'd1000000,    16'd1000,  16'd1000,  17'd0,      0);
    run32(32'hFFFF_FFFF,  16'd65535, 16'd65535, 17'd131070, 0);
    run32(32'd8,          16'd2,     16'd3,     17'd4,      0);
    run32(32'd6,          16'd2,     16'd2,     17'd2,      10);

    // Abandon a computation at iteration 5; outputs must clear without waiting for a clock.
    din = 32'd123456789;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("calc_busy", a_busy, 1'b1);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("arst_in_ready", a_in_ready, 1'b1);
    check("arst_out_valid", a_out_valid, 1'b0);
    check("arst_busy", a_busy, 1'b0);
    check("arst_cstate", a_cstate, 0);
    check("arst_dout", b_dout, 0);
    check("arst_rem", a_rem, 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_valid", a_out_valid, 1'b0);
    run32(32'd144, 16'd12, 16'd12, 17'd0, 0);

    run16(16'd65535);
    check("c_dout_max", c_dout, 8'd255);
    check("c_rem_max", c_rem, 9'd510);
    for (int i = 0; i < 2000; i++) run16(16'($urandom()));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
